// File: rtl/wbu_deword_buffered_if.sv
// Word-in / character-out handshake bundle for the buffered de-word stage.
// The slave side is the de-word stage itself; the master side feeds words and stalls characters.
interface wbu_deword_buffered_if #(
  parameter int LGFIFO = 2
);
  logic              i_stb;
  logic [35:0]       i_word;
  logic              o_busy;
  logic              o_stb;
  logic [6:0]        o_nl_hexbits;
  logic              i_tx_busy;
  logic [LGFIFO:0]   o_fill;

  modport master (
    output i_stb, i_word, i_tx_busy,
    input  o_busy, o_stb, o_nl_hexbits, o_fill
  );

  modport slave (
    input  i_stb, i_word, i_tx_busy,
    output o_busy, o_stb, o_nl_hexbits, o_fill
  );
endinterface

// File: rtl/wbu_deword_buffered.sv
// Buffers 36-bit encoded response words in a small FIFO and streams them out as
// 6-bit characters (MSB first) with an optional trailing newline, one per accept.
module wbu_deword_buffered #(
  parameter int LGFIFO  = 2,
  parameter int NL_MODE = 2
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  wbu_deword_buffered_if.slave  bus
);

  localparam int DEPTH = 1 << LGFIFO;

  typedef enum logic [1:0] {S_IDLE, S_CHAR, S_NL} state_t;

  logic [35:0]       r_mem [DEPTH];
  logic [LGFIFO-1:0] r_wptr, r_rptr;
  logic [LGFIFO:0]   r_fill;
  logic              r_busy;
  state_t            r_state;
  logic              r_stb;
  logic [6:0]        r_hex;
  logic [29:0]       r_sreg;
  logic [2:0]        r_cnt;

  logic              w_push, w_pop, w_empty, w_accept, w_last, w_want_nl;
  logic [LGFIFO:0]   w_fill_nxt;
  logic [35:0]       w_head;

  // Characters per word, chosen by the word's type prefix.
  function automatic logic [2:0] word_len(input logic [35:0] w);
    if (w[35:33] == 3'b000)      word_len = 3'd1;
    else if (w[35:32] == 4'h2)   word_len = 3'd6;
    else if (w[35:32] == 4'h3)   word_len = 3'd2 + {1'b0, w[31:30]};
    else if (w[35:34] == 2'b01)  word_len = 3'd2;
    else if (w[35:34] == 2'b10)  word_len = 3'd1;
    else                         word_len = 3'd6;
  endfunction

  assign w_push    = bus.i_stb && !r_busy;
  assign w_empty   = (r_fill == '0);
  assign w_accept  = r_stb && !bus.i_tx_busy;
  assign w_last    = (r_cnt == 3'd1);
  assign w_head    = r_mem[r_rptr];
  // Mode 2 looks at the registered fill, so a word arriving on the same edge still follows a newline.
  assign w_want_nl = (NL_MODE == 1) || ((NL_MODE == 2) && w_empty);

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = !w_empty;
      S_CHAR:  w_pop = w_accept && w_last && !w_want_nl && !w_empty;
      S_NL:    w_pop = w_accept && !w_empty;
      default: w_pop = 1'b0;
    endcase
  end

  always_comb begin
    w_fill_nxt = r_fill;
    if (w_push && !w_pop)      w_fill_nxt = r_fill + (LGFIFO+1)'(1);
    else if (!w_push && w_pop) w_fill_nxt = r_fill - (LGFIFO+1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= bus.i_word;
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
      r_busy <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + LGFIFO'(1);
      if (w_pop)  r_rptr <= r_rptr + LGFIFO'(1);
      r_fill <= w_fill_nxt;
      r_busy <= (w_fill_nxt == (LGFIFO+1)'(DEPTH));
    end
  end

  // Every pop loads a word, so loading is handled once ahead of the per-state moves.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_state <= S_IDLE;
      r_stb   <= 1'b0;
      r_hex   <= 7'h00;
      r_sreg  <= '0;
      r_cnt   <= 3'd0;
    end else if (w_pop) begin
      r_state <= S_CHAR;
      r_stb   <= 1'b1;
      r_hex   <= {1'b0, w_head[35:30]};
      r_sreg  <= w_head[29:0];
      r_cnt   <= word_len(w_head);
    end else begin
      case (r_state)
        S_CHAR: begin
          if (w_accept) begin
            if (!w_last) begin
              r_hex  <= {1'b0, r_sreg[29:24]};
              r_sreg <= {r_sreg[23:0], 6'd0};
              r_cnt  <= r_cnt - 3'd1;
            end else if (w_want_nl) begin
              r_state <= S_NL;
              r_hex   <= 7'h40;
            end else begin
              r_state <= S_IDLE;
              r_stb   <= 1'b0;
            end
          end
        end
        S_NL: begin
          if (w_accept) begin
            r_state <= S_IDLE;
            r_stb   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy       = r_busy;
  assign bus.o_stb        = r_stb;
  assign bus.o_nl_hexbits = r_hex;
  assign bus.o_fill       = r_fill;

endmodule

// File: tb/tb_wbu_deword_buffered.sv
// Bench for wbu_deword_buffered: three instances (newline modes 0, 1, 2) share one stimulus
// and are checked every cycle against a word-queue model plus literal character logs.
module tb_wbu_deword_buffered;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  tb_stb = 3'b000;
  logic [35:0] tb_word = '0;
  logic        tb_txb = 1'b0;

  always #5 clk = ~clk;

  wbu_deword_buffered_if #(.LGFIFO(2)) b0 ();
  wbu_deword_buffered_if #(.LGFIFO(2)) b1 ();
  wbu_deword_buffered_if #(.LGFIFO(2)) b2 ();

  assign b0.i_stb = tb_stb[0];
  assign b1.i_stb = tb_stb[1];
  assign b2.i_stb = tb_stb[2];
  assign b0.i_word = tb_word;
  assign b1.i_word = tb_word;
  assign b2.i_word = tb_word;
  assign b0.i_tx_busy = tb_txb;
  assign b1.i_tx_busy = tb_txb;
  assign b2.i_tx_busy = tb_txb;

  wbu_deword_buffered #(.LGFIFO(2), .NL_MODE(0)) dut0 (.i_clk(clk), .i_areset_n(rst_n), .bus(b0));
  wbu_deword_buffered #(.LGFIFO(2), .NL_MODE(1)) dut1 (.i_clk(clk), .i_areset_n(rst_n), .bus(b1));
  wbu_deword_buffered #(.LGFIFO(2), .NL_MODE(2)) dut2 (.i_clk(clk), .i_areset_n(rst_n), .bus(b2));

  logic       a_stb [3];
  logic       a_busy[3];
  logic [6:0] a_hex [3];
  logic [2:0] a_fill[3];
  assign a_stb[0] = b0.o_stb;        assign a_stb[1] = b1.o_stb;        assign a_stb[2] = b2.o_stb;
  assign a_busy[0] = b0.o_busy;      assign a_busy[1] = b1.o_busy;      assign a_busy[2] = b2.o_busy;
  assign a_hex[0] = b0.o_nl_hexbits; assign a_hex[1] = b1.o_nl_hexbits; assign a_hex[2] = b2.o_nl_hexbits;
  assign a_fill[0] = b0.o_fill;      assign a_fill[1] = b1.o_fill;      assign a_fill[2] = b2.o_fill;

  int nerr = 0;
  int nchk = 0;

  // Model state: instance k uses newline mode k.
  logic [35:0] wq[3][$];
  logic [6:0]  logq[3][$];
  int          idx[3];
  bit          nlp[3];
  bit          prev_stall[3];
  bit          exp_stb[3];
  logic [6:0]  prev_hex[3];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int nchars(input logic [35:0] w);
    if (w[35:33] == 3'b000) return 1;
    if (w[35:32] == 4'h2)   return 6;
    if (w[35:32] == 4'h3)   return 2 + int'(w[31:30]);
    if (w[35:34] == 2'b01)  return 2;
    if (w[35:34] == 2'b10)  return 1;
    return 6;
  endfunction

  function automatic logic [5:0] chunk(input logic [35:0] w, input int i);
    logic [35:0] s;
    s = w << (6 * i);
    return s[35:30];
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        wq[k].delete();
        idx[k] = 0;
        nlp[k] = 1'b0;
        prev_stall[k] = 1'b0;
        exp_stb[k] = 1'b0;
      end else begin
        logic [6:0] e;
        bit acc;
        if (prev_stall[k]) begin
          chk($sformatf("stall_stb%0d", k), int'(a_stb[k]), 1);
          chk($sformatf("stall_hex%0d", k), int'(a_hex[k]), int'(prev_hex[k]));
        end
        if (exp_stb[k]) chk($sformatf("bubble%0d", k), int'(a_stb[k]), 1);
        acc = a_stb[k] && !tb_txb;
        exp_stb[k] = 1'b0;
        if (acc) begin
          if (nlp[k]) begin
            e = 7'h40;
            nlp[k] = 1'b0;
            chk($sformatf("char%0d", k), int'(a_hex[k]), int'(e));
          end else if (wq[k].size() > 0) begin
            e = {1'b0, chunk(wq[k][0], idx[k])};
            idx[k]++;
            if (idx[k] == nchars(wq[k][0])) begin
              void'(wq[k].pop_front());
              idx[k] = 0;
              nlp[k] = (k == 1) || (k == 2 && wq[k].size() == 0);
            end
            chk($sformatf("char%0d", k), int'(a_hex[k]), int'(e));
          end else begin
            nerr++;
            nchk++;
            $display("FAIL unexpected_char%0d: got %0h expected no character", k, a_hex[k]);
          end
          logq[k].push_back(a_hex[k]);
          exp_stb[k] = nlp[k] || (idx[k] > 0);
        end
        prev_stall[k] = a_stb[k] && tb_txb;
        prev_hex[k] = a_hex[k];
        if (tb_stb[k] && !a_busy[k]) wq[k].push_back(tb_word);
      end
    end
  end

  task automatic finish_push();
    logic [2:0] done;
    int guard;
    guard = 0;
    while (tb_stb != 3'b000 && guard < 200) begin
      @(negedge clk);
      done = tb_stb & ~{a_busy[2], a_busy[1], a_busy[0]};
      @(posedge clk);
      #1;
      tb_stb = tb_stb & ~done;
      guard++;
    end
    if (tb_stb != 3'b000) chk("push_timeout", int'(tb_stb), 0);
    tb_stb = 3'b000;
  endtask

  task automatic push_word(input logic [35:0] w);
    tb_word = w;
    tb_stb = 3'b111;
    finish_push();
  endtask

  task automatic wait_idle();
    int quiet;
    int guard;
    bit idle;
    quiet = 0;
    guard = 0;
    while (quiet < 3 && guard < 300) begin
      @(negedge clk);
      idle = 1'b1;
      for (int k = 0; k < 3; k++)
        if (a_stb[k] || a_fill[k] != 3'd0 || wq[k].size() != 0 || nlp[k]) idle = 1'b0;
      quiet = idle ? quiet + 1 : 0;
      guard++;
    end
    chk("idle_reached", int'(quiet >= 3), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 3; k++) logq[k].delete();
  endtask

  task automatic chk_log(input int k, input string nm, input logic [6:0] e[$]);
    chk($sformatf("%s_len%0d", nm, k), logq[k].size(), e.size());
    for (int i = 0; i < e.size() && i < logq[k].size(); i++)
      chk($sformatf("%s_%0d_%0d", nm, k, i), int'(logq[k][i]), int'(e[i]));
  endtask

  task automatic chk_quiet(input string nm, input int fill, input int busy);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_stb%0d", nm, k), int'(a_stb[k]), 0);
      chk($sformatf("%s_hex%0d", nm, k), int'(a_hex[k]), 0);
      chk($sformatf("%s_fill%0d", nm, k), int'(a_fill[k]), fill);
      chk($sformatf("%s_busy%0d", nm, k), int'(a_busy[k]), busy);
    end
  endtask

  logic [6:0] e6[$];
  logic [6:0] ex[$];
  logic [6:0] held;

  initial begin
    e6 = '{7'h08, 7'h12, 7'h0D, 7'h05, 7'h19, 7'h38};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset", 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: six-character word, two-cycle latency, consecutive characters
    clear_logs();
    tb_word = 36'h2_1234_5678;
    tb_stb = 3'b111;
    @(posedge clk);
    #1;
    tb_stb = 3'b000;
    @(negedge clk);
    chk("latency_c1_stb", int'(a_stb[2]), 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("t1_stb_%0d", i), int'(a_stb[2]), 1);
      chk($sformatf("t1_hex_%0d", i), int'(a_hex[2]), (i < 6) ? int'(e6[i]) : 'h40);
    end
    wait_idle();
    chk_log(0, "t1", e6);
    ex = e6; ex.push_back(7'h40);
    chk_log(1, "t1", ex);
    chk_log(2, "t1", ex);

    // Test 2: three-character and one-character words
    clear_logs();
    push_word(36'h3_4000_0000);
    wait_idle();
    chk_log(0, "t2a", '{7'h0D, 7'h00, 7'h00});
    chk_log(1, "t2a", '{7'h0D, 7'h00, 7'h00, 7'h40});
    chk_log(2, "t2a", '{7'h0D, 7'h00, 7'h00, 7'h40});
    clear_logs();
    push_word(36'h0_0000_0000);
    wait_idle();
    chk_log(0, "t2b", '{7'h00});
    chk_log(1, "t2b", '{7'h00, 7'h40});
    chk_log(2, "t2b", '{7'h00, 7'h40});

    // Test 3: two words back to back under the three newline policies
    clear_logs();
    push_word(36'h4_0000_0000);
    push_word(36'h8_C000_0000);
    wait_idle();
    chk_log(0, "t3", '{7'h10, 7'h00, 7'h23});
    chk_log(1, "t3", '{7'h10, 7'h00, 7'h40, 7'h23, 7'h40});
    chk_log(2, "t3", '{7'h10, 7'h00, 7'h23, 7'h40});

    // Test 4: five-cycle stall on the third character
    clear_logs();
    push_word(36'h2_1234_5678);
    repeat (3) begin @(posedge clk); #1; end
    tb_txb = 1'b1;
    held = a_hex[2];
    repeat (5) begin @(posedge clk); #1; end
    chk("t4_held_hex", int'(a_hex[2]), 'h0D);
    chk("t4_held_vs_start", int'(a_hex[2]), int'(held));
    chk("t4_held_stb", int'(a_stb[2]), 1);
    tb_txb = 1'b0;
    wait_idle();
    ex = e6; ex.push_back(7'h40);
    chk_log(2, "t4", ex);
    chk_log(0, "t4", e6);

    // Test 5: fill the FIFO behind a stalled output
    clear_logs();
    tb_txb = 1'b1;
    for (int i = 1; i <= 5; i++) push_word({6'(32 + i), 30'd0});
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t5_fill%0d", k), int'(a_fill[k]), 4);
      chk($sformatf("t5_busy%0d", k), int'(a_busy[k]), 1);
    end
    tb_word = {6'd38, 30'd0};
    tb_stb = 3'b111;
    repeat (3) begin @(posedge clk); #1; end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t5_hold_fill%0d", k), int'(a_fill[k]), 4);
      chk($sformatf("t5_hold_busy%0d", k), int'(a_busy[k]), 1);
      chk($sformatf("t5_held_off%0d", k), wq[k].size(), 5);
    end
    chk("t5_first_char", int'(a_hex[2]), 'h21);
    tb_txb = 1'b0;
    finish_push();
    wait_idle();
    ex.delete();
    for (int i = 1; i <= 6; i++) ex.push_back(7'(32 + i));
    chk_log(0, "t5", ex);
    ex.push_back(7'h40);
    chk_log(2, "t5", ex);
    ex.delete();
    for (int i = 1; i <= 6; i++) begin ex.push_back(7'(32 + i)); ex.push_back(7'h40); end
    chk_log(1, "t5", ex);

    // Test 6: asynchronous reset while the third character is showing
    clear_logs();
    push_word(36'h2_1234_5678);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #2;
    chk("t6_pre_hex", int'(a_hex[2]), 'h0D);
    rst_n = 1'b0;
    #1;
    chk_quiet("t6_reset", 0, 0);
    chk_log(2, "t6_pre", '{7'h08, 7'h12});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("t6_quiet_stb%0d", k), int'(a_stb[k]), 0);
    @(posedge clk);
    #1;
    clear_logs();
    push_word(36'h3_4000_0000);
    wait_idle();
    chk_log(0, "t6", '{7'h0D, 7'h00, 7'h00});
    chk_log(2, "t6", '{7'h0D, 7'h00, 7'h00, 7'h40});

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
